// File: rtl/charge_sched_pkg.sv
// Shared types and constants for the charge slot scheduler.
package charge_sched_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StDead  = 2'd2
    } sched_state_e;

    localparam logic [6:0] SLOW_START_PCT = 7'd80;
    localparam logic [6:0] FULL_PCT       = 7'd100;
    localparam logic [6:0] LOWBATT_PCT    = 7'd20;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of eligible strictly after
// last_id, searching upward and wrapping (last_id itself is checked last).
module rr_arbiter #(
    parameter int unsigned NUM_BAYS = 4
) (
    input  logic [NUM_BAYS-1:0]         eligible,
    input  logic [$clog2(NUM_BAYS)-1:0] last_id,
    output logic                        found,
    output logic [$clog2(NUM_BAYS)-1:0] winner_id
);

    localparam int unsigned IdW = $clog2(NUM_BAYS);

    int unsigned idx;

    // Scan offsets 1..NUM_BAYS from last_id; the first eligible hit wins.
    always_comb begin
        found     = 1'b0;
        winner_id = last_id;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_BAYS; k++) begin
            idx = (32'(last_id) + k) % NUM_BAYS;
            if (!found && eligible[IdW'(idx)]) begin
                found     = 1'b1;
                winner_id = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/charge_slot_scheduler.sv
// Time-slices one fast-charge stage among NUM_BAYS bays with round-robin
// grants, slice timeout, early termination and a dead time between slices.
// Optional feature: define CHARGE_SCHED_LOWBATT_PRIO_EN to serve bays below
// LOWBATT_PCT first.
module charge_slot_scheduler
    import charge_sched_pkg::*;
#(
    parameter int unsigned NUM_BAYS    = 4,
    parameter int unsigned SLOT_CYCLES = 16,
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned TEMP_LIMIT  = 45,
    parameter int unsigned TEMP_HYST   = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_BAYS-1:0]         req,
    input  logic [7*NUM_BAYS-1:0]       temp_flat,
    input  logic [7*NUM_BAYS-1:0]       percent_flat,
    output logic [NUM_BAYS-1:0]         grant,
    output logic [$clog2(NUM_BAYS)-1:0] grant_id,
    output logic                        fast_mode,
    output logic [NUM_BAYS-1:0]         thermal_lock,
    output logic                        busy
);

    localparam int unsigned IdW   = $clog2(NUM_BAYS);
    localparam int unsigned SlotW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned DeadW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [6:0]  TempSet = 7'(TEMP_LIMIT);
    localparam logic [6:0]  TempClr = 7'(TEMP_LIMIT - TEMP_HYST);

    sched_state_e        state_q;
    logic [SlotW-1:0]    slot_cnt_q;
    logic [DeadW-1:0]    dead_cnt_q;
    logic [IdW-1:0]      last_id_q;

    logic [6:0]          temp [NUM_BAYS];
    logic [6:0]          pct  [NUM_BAYS];
    logic [NUM_BAYS-1:0] hot;
    logic [NUM_BAYS-1:0] elig;
    logic                found;
    logic [IdW-1:0]      win_id;
    logic                start;
    logic                end_slice;

    // Unpack bay fields; a bay hitting the limit this cycle is already treated
    // as locked so it can never be granted on the edge its lock sets.
    always_comb begin
        for (int i = 0; i < NUM_BAYS; i++) begin
            temp[i] = temp_flat[7*i +: 7];
            pct[i]  = percent_flat[7*i +: 7];
            hot[i]  = temp[i] >= TempSet;
            elig[i] = req[i] & ~thermal_lock[i] & ~hot[i] & (pct[i] < FULL_PCT);
        end
    end

`ifdef CHARGE_SCHED_LOWBATT_PRIO_EN
    logic [NUM_BAYS-1:0] low_elig;
    logic                low_found;
    logic                all_found;
    logic [IdW-1:0]      low_id;
    logic [IdW-1:0]      all_id;

    // Low-battery class: eligible bays below LOWBATT_PCT.
    always_comb begin
        for (int i = 0; i < NUM_BAYS; i++) begin
            low_elig[i] = elig[i] & (pct[i] < LOWBATT_PCT);
        end
    end

    rr_arbiter #(.NUM_BAYS(NUM_BAYS)) u_arb_low (
        .eligible  (low_elig),
        .last_id   (last_id_q),
        .found     (low_found),
        .winner_id (low_id)
    );

    rr_arbiter #(.NUM_BAYS(NUM_BAYS)) u_arb_all (
        .eligible  (elig),
        .last_id   (last_id_q),
        .found     (all_found),
        .winner_id (all_id)
    );

    assign found  = low_found | all_found;
    assign win_id = low_found ? low_id : all_id;
`else
    rr_arbiter #(.NUM_BAYS(NUM_BAYS)) u_arb (
        .eligible  (elig),
        .last_id   (last_id_q),
        .found     (found),
        .winner_id (win_id)
    );
`endif

    // Slice end and new-grant decisions for the current cycle.
    always_comb begin
        end_slice = (slot_cnt_q == '0) | ~req[grant_id] | (pct[grant_id] >= FULL_PCT) |
                    thermal_lock[grant_id] | hot[grant_id];
        start     = found & ((state_q == StIdle) |
                             ((state_q == StDead) & (dead_cnt_q == '0)));
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            grant      <= '0;
            grant_id   <= '0;
            fast_mode  <= 1'b0;
            busy       <= 1'b0;
            slot_cnt_q <= '0;
            dead_cnt_q <= '0;
            last_id_q  <= IdW'(NUM_BAYS - 1);
        end else if (start) begin
            state_q    <= StGrant;
            grant      <= NUM_BAYS'(1) << win_id;
            grant_id   <= win_id;
            last_id_q  <= win_id;
            fast_mode  <= pct[win_id] < SLOW_START_PCT;
            busy       <= 1'b1;
            slot_cnt_q <= SlotW'(SLOT_CYCLES - 1);
        end else begin
            case (state_q)
                StIdle: begin
                    grant     <= '0;
                    fast_mode <= 1'b0;
                    busy      <= 1'b0;
                end
                StGrant: begin
                    if (end_slice) begin
                        state_q    <= StDead;
                        grant      <= '0;
                        fast_mode  <= 1'b0;
                        dead_cnt_q <= DeadW'(DEAD_CYCLES - 1);
                    end else begin
                        slot_cnt_q <= slot_cnt_q - 1'b1;
                        fast_mode  <= pct[grant_id] < SLOW_START_PCT;
                    end
                end
                StDead: begin
                    if (dead_cnt_q == '0) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        dead_cnt_q <= dead_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    grant     <= '0;
                    fast_mode <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Per-bay thermal lock with hysteresis, independent of the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thermal_lock <= '0;
        end else begin
            for (int i = 0; i < NUM_BAYS; i++) begin
                if (hot[i]) begin
                    thermal_lock[i] <= 1'b1;
                end else if (temp[i] <= TempClr) begin
                    thermal_lock[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/charge_slot_scheduler.md
# charge_slot_scheduler

Time-slices one shared fast-charge power stage among `NUM_BAYS` battery bays, each of which has its own temperature controller. It grants the stage to one requesting bay at a time in round-robin order and ends a slice on timeout, request drop, full charge or over-temperature. Between grants it inserts a dead time with the stage off. It sits above the per-bay temperature/charging controllers and drives their `charging` inputs.

## Interface
- `NUM_BAYS`, 4: number of bays; legal range 2..8.
- `SLOT_CYCLES`, 16: maximum cycles one grant is held; must be ≥1.
- `DEAD_CYCLES`, 4: grant-free cycles between slices; must be ≥1.
- `TEMP_LIMIT`, 45: °C at or above which a bay is thermally locked.
- `TEMP_HYST`, 3: lock clears at `temp <= TEMP_LIMIT - TEMP_HYST`.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req` in NUM_BAYS: per-bay charge request, level.
- `temp_flat` in 7*NUM_BAYS: per-bay temperature in °C; bay i is at bits [7i+6:7i].
- `percent_flat` in 7*NUM_BAYS: per-bay state of charge 0..100, packed the same way.
- `grant` out NUM_BAYS: one-hot or zero; drives the bay `charging` inputs.
- `grant_id` out clog2(NUM_BAYS): index of the granted bay; holds its last value when no bay is granted.
- `fast_mode` out 1: 1 when the granted bay's percent is below 80; 0 when no bay is granted.
- `thermal_lock` out NUM_BAYS: per-bay lock flags.
- `busy` out 1: 1 in GRANT or DEAD.

## Operation
- Eligibility per bay: `req[i] & ~thermal_lock[i] & (percent[i] < 100)`.
- States: IDLE, GRANT, DEAD. Reset enters IDLE.
- IDLE: if any bay is eligible, go to GRANT. The winner is the first eligible index after `last_id`, searching upward and wrapping. Load `slot_cnt = SLOT_CYCLES-1`.
- GRANT: `grant` is one-hot at `grant_id`. `slot_cnt` decrements each cycle. The slice ends, going to DEAD with `dead_cnt = DEAD_CYCLES-1`, when any of these is true:
  - `slot_cnt == 0`
  - `req[grant_id] == 0`
  - `percent[grant_id] >= 100`
  - `thermal_lock[grant_id]` is set, or its set condition holds this cycle
- DEAD: `grant = 0`. `dead_cnt` decrements. At 0, go to IDLE, or directly to GRANT if a bay is eligible; arbitration is the same as in IDLE.
- `last_id` updates to `grant_id` on every GRANT entry.
- A bay that is still eligible may win again in the next slice if no other bay is eligible.
- Thermal lock (registered, independent of the FSM): set when `temp >= TEMP_LIMIT`; clear when `temp <= TEMP_LIMIT - TEMP_HYST`; otherwise hold.
- All comparisons are unsigned 7-bit. Counters are sized to clog2 of the corresponding parameter.
- Illegal state encoding: return to IDLE with `grant = 0`.

## Timing
- Reset values: `grant = 0`, `grant_id = 0`, `fast_mode = 0`, `thermal_lock = 0`, `busy = 0`, `last_id = NUM_BAYS-1`. With these values bay 0 wins first.
- All outputs are registered.
- Request latency: `req` rising at cycle t while idle gives `grant` at t+1.
- A slice holds `grant` for at most `SLOT_CYCLES` consecutive cycles.
- Early termination: when the termination condition is sampled at cycle t, `grant` is 0 at t+1.
- Dead time: exactly `DEAD_CYCLES` cycles with `grant = 0` between any two grants.
- `fast_mode` tracks the granted bay's percent with 1-cycle latency.
- Thermal lock is evaluated on the same edge as grant termination, so an over-temperature bay is never granted in the following cycle.
- Reset asserted mid-slice clears `grant` immediately (asynchronous).

## Configuration
- `CHARGE_SCHED_LOWBATT_PRIO_EN` defined: eligible bays with percent < 20 form a priority class. Round-robin runs within that class first and falls back to all eligible bays only if the class is empty. Each class uses the same `last_id` pointer.
- Undefined: plain round-robin across all eligible bays.

## Structure
- Package `charge_sched_pkg` holds:
  - the state enum (IDLE/GRANT/DEAD)
  - `SLOW_START_PCT = 80`, `FULL_PCT = 100`, `LOWBATT_PCT = 20`
- Sub-module `rr_arbiter`: combinational round-robin pick.
  - Inputs: eligible mask and `last_id`.
  - Outputs: `found` and `winner_id`.
  - Under the macro it is instantiated twice (low-battery class and all bays), with a mux between the results.

## Test plan
- Bays 0 and 2 request, all at 30%/27°C, SLOT=16, DEAD=4. Required response: bay 0 is granted for 16 cycles, then 4 dead cycles, then bay 2 for 16 cycles, then bay 0 again.
- Bay 1 is granted and its temp steps to 45 at cycle t. Required response: `grant = 0` and `thermal_lock[1] = 1` at t+1. The lock stays set at temp 43 and clears at 42.
- Granted bay's percent goes from 99 to 100. Required response: slice ends next cycle and the bay is not re-granted while at 100.
- Granted bay percent 79 → 80. Required response: `fast_mode` goes 1 → 0 one cycle later and the grant continues.
- With the macro: bay 0 at 50%, bay 3 at 10%, both requesting. Required response: bay 3 is granted first. Without the macro, bay 0 is granted first.
- Reset pulse mid-GRANT. Required response: `grant = 0` immediately, and the first grant after reset goes to the lowest eligible index.
